axis_dcmac_seg_tx: RTL and testbench
====================================

# axis_dcmac_seg_tx

Parametrised TX adapter between a CASPER AXI-Stream source and the DCMAC segmented transmit client interface. It slices each AXIS beat into NUM_SEG 128-bit segments and generates per-segment ena/sop/eop/mty/err, along with per-segment-pair vld. Flow control covers DCMAC tready and almost-full throttling through a 2-entry skid buffer. It is the successor of the fixed 1024-bit 400G adapter and sits between the CASPER packetiser and the DCMAC TX client port.

## Interface
- NUM_SEG, 8: number of 128-bit segments; even, 2..12; AXIS width is NUM_SEG*128.
- CH_ID, 0: constant driven on dcmac_tx_id, 3 bits.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- casper_tx_tdata  in  NUM_SEG*128  AXIS data, byte 0 = bits [7:0].
- casper_tx_tkeep  in  NUM_SEG*16  byte enables, contiguous from LSB.
- casper_tx_tvalid  in  1  AXIS valid.
- casper_tx_tlast  in  1  last beat of packet.
- casper_tx_tuser  in  1  packet error; sampled on the tlast beat only.
- casper_tx_tready  out  1  AXIS ready.
- dcmac_tx_id  out  3  equals CH_ID.
- dcmac_tx_dat  out  NUM_SEG*128  segment k = bits [128k+127:128k].
- dcmac_tx_ena, dcmac_tx_sop, dcmac_tx_eop, dcmac_tx_err  out  NUM_SEG each  per-segment flags.
- dcmac_tx_mty  out  NUM_SEG*4  empty bytes per segment.
- dcmac_tx_vld  out  NUM_SEG/2  per-pair valid.
- dcmac_tx_tready  in  1  DCMAC accepts the current output word.
- dcmac_tx_af  in  1  DCMAC almost full.
- proto_err  out  1  sticky protocol violation flag; cleared by rst only.
- pkt_cnt, err_cnt  out  32 each  statistics; see Configuration.

## Operation
- Segment k is enabled when any bit of tkeep[16k+15:16k] is set.
- mty[k] = 16 - popcount(keep slice), 4-bit. A full segment gives 0; 1 byte gives 15. mty is 0 on disabled segments.
- State machine, IDLE / IN_PKT:
  - IDLE: the first accepted beat sets sop on segment 0. The next state is IN_PKT, or stays IDLE if tlast is set.
  - IN_PKT: the beat accepted with tlast returns the machine to IDLE.
- eop is set on the highest enabled segment of the tlast beat.
- tuser=1 on the tlast beat sets err on the eop segment only.
- The following beats are illegal, but each is still forwarded and sets proto_err:
  - a non-last beat with any keep bit clear: err is set on its highest enabled segment;
  - non-contiguous keep: err is set on all enabled segments of the beat;
  - all-zero keep: the word is emitted with ena=0 and vld=0. If tlast is set, the state returns to IDLE with no eop.
- dcmac_tx_vld[p] = word valid AND (ena[2p] OR ena[2p+1]).
- Data, ena, sop, eop, mty and err are all zero on segments whose ena is 0.

## Timing
- Output stage is a register plus a 1-entry skid register.
- A beat is accepted when casper_tx_tvalid && casper_tx_tready at a rising edge.
- casper_tx_tready is registered and equals "skid register empty".
- The output word advances when dcmac_tx_tready=1 and dcmac_tx_af=0. af=1 holds the word exactly like tready=0.
- Latency: a beat accepted at edge N is on the dcmac outputs from edge N to N+1 when the output is empty.
- Throughput: one beat per cycle while tready=1 and af=0.
- A stall asserted at edge N deasserts casper_tx_tready at edge N+1. At most one beat is taken into skid; no beat is lost or duplicated.
- Reset: every output is 0 while rst=1, except dcmac_tx_id=CH_ID. This covers casper_tx_tready, all dcmac flags/data, proto_err and counters.
- casper_tx_tready is 1 on the first cycle after rst falls.
- Reset mid-packet flushes both registers and returns the state to IDLE; the next beat carries sop.

## Configuration
- AXIS_DCMAC_STATS_EN defined:
  - pkt_cnt increments on each eop word leaving the output register;
  - err_cnt increments on each leaving word with any err bit set;
  - both wrap at 2^32.
- Undefined: counter logic is not built and pkt_cnt/err_cnt are tied to 0.

## Test plan
- 8192-byte packets, NUM_SEG=8, tready=1, af=0, 1-cycle gap -> 64 words per packet:
  - sop on seg0 of word 0 only;
  - eop on seg7 of word 63 with mty 0;
  - pkt_cnt=N after N packets (STATS_EN).
- 129-byte packet: beat1 keep=128'h1 -> word1 has ena=8'h01, eop[0]=1, mty[0]=15, vld=4'b0001.
- Back-to-back 4-beat packets with dcmac_tx_tready low for 5 cycles mid-packet, then af high 3 cycles -> output sequence is identical to the unstalled run and casper_tx_tready drops one cycle after the stall.
- tuser=1 on the tlast beat -> err only on the eop segment; err_cnt=1; proto_err stays 0.
- Non-last beat with keep=128'h00FF -> err[0]=1, proto_err=1 and held until reset.
- rst pulsed on beat 3 of a 10-beat packet -> outputs 0 during rst; the following beat is emitted with sop[0]=1.

Source files
------------

// File: rtl/axis_dcmac_seg_tx.sv
// axis_dcmac_seg_tx: AXIS to DCMAC segmented TX adapter with a 2-entry output/skid stage.
// Optional statistics counters are built when AXIS_DCMAC_STATS_EN is defined.
module axis_dcmac_seg_tx #(
   parameter int NUM_SEG = 8,
   parameter logic [2:0] CH_ID = 3'd0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SEG*128-1:0] casper_tx_tdata,
   input  logic [NUM_SEG*16-1:0]  casper_tx_tkeep,
   input  logic                   casper_tx_tvalid,
   input  logic                   casper_tx_tlast,
   input  logic                   casper_tx_tuser,
   output logic                   casper_tx_tready,
   output logic [2:0]             dcmac_tx_id,
   output logic [NUM_SEG*128-1:0] dcmac_tx_dat,
   output logic [NUM_SEG-1:0]     dcmac_tx_ena,
   output logic [NUM_SEG-1:0]     dcmac_tx_sop,
   output logic [NUM_SEG-1:0]     dcmac_tx_eop,
   output logic [NUM_SEG-1:0]     dcmac_tx_err,
   output logic [NUM_SEG*4-1:0]   dcmac_tx_mty,
   output logic [NUM_SEG/2-1:0]   dcmac_tx_vld,
   input  logic                   dcmac_tx_tready,
   input  logic                   dcmac_tx_af,
   output logic                   proto_err,
   output logic [31:0]            pkt_cnt,
   output logic [31:0]            err_cnt
);
   localparam int DW = NUM_SEG*128;
   localparam int KW = NUM_SEG*16;
   localparam int WW = DW + NUM_SEG*8;
   typedef enum logic {IDLE, IN_PKT} state_t;
   state_t state;
   logic [WW-1:0] ow, sw;
   logic ov, sv, seen;
   logic [NUM_SEG-1:0] ena, hi, sop, eop, err;
   logic [NUM_SEG*4-1:0] mty;
   logic [DW-1:0] dat;
   logic noncontig, short_beat, bad, acc, go, adv;
   // contiguous-from-LSB keep has no set bit above a clear bit
   assign noncontig = |(casper_tx_tkeep & (casper_tx_tkeep + KW'(1)));
   assign short_beat = !casper_tx_tlast && !(&casper_tx_tkeep);
   assign bad = noncontig || short_beat || !(|casper_tx_tkeep);
   assign acc = casper_tx_tvalid && casper_tx_tready;
   assign go = dcmac_tx_tready && !dcmac_tx_af;
   assign adv = !ov || go;
   always_comb begin
      seen = 1'b0;
      hi = '0;
      ena = '0;
      mty = '0;
      dat = '0;
      sop = '0;
      for (int k = NUM_SEG-1; k >= 0; k--) begin
         ena[k] = |casper_tx_tkeep[16*k +: 16];
         hi[k] = ena[k] & ~seen;
         seen = seen | ena[k];
         mty[4*k +: 4] = ena[k] ? 4'(16 - $countones(casper_tx_tkeep[16*k +: 16])) : 4'd0;
         dat[128*k +: 128] = ena[k] ? casper_tx_tdata[128*k +: 128] : '0;
      end
      eop = casper_tx_tlast ? hi : '0;
      err = noncontig ? ena : (((casper_tx_tlast && casper_tx_tuser) || short_beat) ? hi : '0);
      sop[0] = (state == IDLE) && ena[0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ov <= 1'b0;
         sv <= 1'b0;
         ow <= '0;
         sw <= '0;
         casper_tx_tready <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (acc) begin
            state <= casper_tx_tlast ? IDLE : IN_PKT;
            if (bad) proto_err <= 1'b1;
         end
         if (adv) begin
            ov <= sv || acc;
            ow <= sv ? sw : (acc ? {dat, mty, ena, sop, eop, err} : '0);
         end
         if (sv) sv <= !adv;
         else if (acc && !adv) begin
            sw <= {dat, mty, ena, sop, eop, err};
            sv <= 1'b1;
         end
         casper_tx_tready <= sv ? adv : !(acc && !adv);
      end
   end
   assign dcmac_tx_id = CH_ID;
   assign {dcmac_tx_dat, dcmac_tx_mty, dcmac_tx_ena, dcmac_tx_sop, dcmac_tx_eop, dcmac_tx_err} = ow;
   for (genvar p = 0; p < NUM_SEG/2; p++) begin : g_vld
      assign dcmac_tx_vld[p] = dcmac_tx_ena[2*p] | dcmac_tx_ena[2*p+1];
   end
`ifdef AXIS_DCMAC_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else if (ov && go) begin
         if (|dcmac_tx_eop) pkt_cnt <= pkt_cnt + 32'd1;
         if (|dcmac_tx_err) err_cnt <= err_cnt + 32'd1;
      end
   end
`else
   assign pkt_cnt = '0;
   assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_axis_dcmac_seg_tx.sv
// tb_axis_dcmac_seg_tx: randomized bench for axis_dcmac_seg_tx against a byte-level reference model.
module tb_axis_dcmac_seg_tx;
   localparam int NS = 8;
   localparam int DW = NS*128;
   localparam int KW = NS*16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [DW-1:0] casper_tx_tdata = '0;
   logic [KW-1:0] casper_tx_tkeep = '0;
   logic casper_tx_tvalid = 1'b0, casper_tx_tlast = 1'b0, casper_tx_tuser = 1'b0;
   logic casper_tx_tready;
   logic [2:0] dcmac_tx_id;
   logic [DW-1:0] dcmac_tx_dat;
   logic [NS-1:0] dcmac_tx_ena, dcmac_tx_sop, dcmac_tx_eop, dcmac_tx_err;
   logic [NS*4-1:0] dcmac_tx_mty;
   logic [NS/2-1:0] dcmac_tx_vld;
   logic dcmac_tx_tready = 1'b1, dcmac_tx_af = 1'b0;
   logic proto_err;
   logic [31:0] pkt_cnt, err_cnt;
   always #5 clk = ~clk;
   axis_dcmac_seg_tx #(.NUM_SEG(NS), .CH_ID(3'd5)) dut (
      .clk(clk), .rst(rst),
      .casper_tx_tdata(casper_tx_tdata), .casper_tx_tkeep(casper_tx_tkeep),
      .casper_tx_tvalid(casper_tx_tvalid), .casper_tx_tlast(casper_tx_tlast),
      .casper_tx_tuser(casper_tx_tuser), .casper_tx_tready(casper_tx_tready),
      .dcmac_tx_id(dcmac_tx_id), .dcmac_tx_dat(dcmac_tx_dat),
      .dcmac_tx_ena(dcmac_tx_ena), .dcmac_tx_sop(dcmac_tx_sop),
      .dcmac_tx_eop(dcmac_tx_eop), .dcmac_tx_err(dcmac_tx_err),
      .dcmac_tx_mty(dcmac_tx_mty), .dcmac_tx_vld(dcmac_tx_vld),
      .dcmac_tx_tready(dcmac_tx_tready), .dcmac_tx_af(dcmac_tx_af),
      .proto_err(proto_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
   );
   typedef struct packed {
      logic [DW-1:0] dat;
      logic [NS*4-1:0] mty;
      logic [NS-1:0] ena, sop, eop, err;
   } word_t;
   word_t q[$];
   bit in_pkt = 1'b0, exp_perr = 1'b0, stall_en = 1'b0;
   int exp_pkts = 0, exp_errs = 0;
   int total = 0, bad = 0;
   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // reference: count bytes per segment and scan keep bit by bit
   function automatic void model(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last, input bit user);
      word_t w = '0;
      int top = -1;
      int nz;
      bit contig = 1'b1, gap = 1'b0;
      for (int b = 0; b < KW; b++) begin
         if (!k[b]) gap = 1'b1;
         else if (gap) contig = 1'b0;
      end
      for (int s = 0; s < NS; s++) begin
         nz = 0;
         for (int b = 0; b < 16; b++) nz += int'(k[16*s+b]);
         if (nz > 0) begin
            w.ena[s] = 1'b1;
            w.mty[4*s +: 4] = 4'(16 - nz);
            w.dat[128*s +: 128] = d[128*s +: 128];
            top = s;
         end
      end
      if (!in_pkt && w.ena[0]) w.sop[0] = 1'b1;
      if (top >= 0) begin
         if (last) w.eop[top] = 1'b1;
         if (last && user) w.err[top] = 1'b1;
         if (!last && k != '1) w.err[top] = 1'b1;
      end
      if (!contig) w.err = w.ena;
      if (!contig || k == '0 || (!last && k != '1)) exp_perr = 1'b1;
      in_pkt = !last;
      if (w.ena != '0) begin
         q.push_back(w);
         if (w.eop != '0) exp_pkts++;
         if (w.err != '0) exp_errs++;
      end
   endfunction
   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last, input bit user);
      bit t;
      int n = 0;
      casper_tx_tdata = d;
      casper_tx_tkeep = k;
      casper_tx_tlast = last;
      casper_tx_tuser = user;
      casper_tx_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         t = casper_tx_tready;
         @(posedge clk);
         #1;
         n++;
         if (t) break;
         if (n > 500) begin
            chk("accept_timeout", DW'(0), DW'(1));
            break;
         end
      end
      if (t) model(d, k, last, user);
      casper_tx_tvalid = 1'b0;
   endtask
   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction
   function automatic logic [KW-1:0] keep_n(input int n);
      logic [KW-1:0] f = '1;
      return f >> (KW - n);
   endfunction
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_empty", DW'(q.size()), DW'(0));
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic chk_stats();
`ifdef AXIS_DCMAC_STATS_EN
      chk("pkt_cnt", DW'(pkt_cnt), DW'(exp_pkts));
      chk("err_cnt", DW'(err_cnt), DW'(exp_errs));
`else
      chk("pkt_cnt_off", DW'(pkt_cnt), DW'(0));
      chk("err_cnt_off", DW'(err_cnt), DW'(0));
`endif
   endtask
   initial forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
         dcmac_tx_tready = $urandom_range(0, 3) != 0;
         dcmac_tx_af = $urandom_range(0, 5) == 0;
      end
   end
   initial begin
      word_t w;
      logic [NS/2-1:0] ev;
      forever begin
         @(negedge clk);
         if (!rst && dcmac_tx_tready && !dcmac_tx_af && |dcmac_tx_ena) begin
            if (q.size() == 0) chk("extra_word", DW'(dcmac_tx_ena), DW'(0));
            else begin
               w = q.pop_front();
               for (int p = 0; p < NS/2; p++) ev[p] = w.ena[2*p] | w.ena[2*p+1];
               chk("dat", dcmac_tx_dat, w.dat);
               chk("ena", DW'(dcmac_tx_ena), DW'(w.ena));
               chk("sop", DW'(dcmac_tx_sop), DW'(w.sop));
               chk("eop", DW'(dcmac_tx_eop), DW'(w.eop));
               chk("err", DW'(dcmac_tx_err), DW'(w.err));
               chk("mty", DW'(dcmac_tx_mty), DW'(w.mty));
               chk("vld", DW'(dcmac_tx_vld), DW'(ev));
            end
         end
      end
   end
   initial begin
      int nb;
      bit last;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready", DW'(casper_tx_tready), DW'(0));
      chk("rst_ena", DW'(dcmac_tx_ena), DW'(0));
      chk("rst_dat", dcmac_tx_dat, DW'(0));
      chk("rst_vld", DW'(dcmac_tx_vld), DW'(0));
      chk("rst_id", DW'(dcmac_tx_id), DW'(5));
      chk("rst_perr", DW'(proto_err), DW'(0));
      chk("rst_pkt", DW'(pkt_cnt), DW'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("tready_after_rst", DW'(casper_tx_tready), DW'(1));
      send(rnd_data(), '1, 1'b1, 1'b0);
      chk("latency_sop", DW'(dcmac_tx_sop), DW'(8'h01));
      chk("latency_eop", DW'(dcmac_tx_eop), DW'(8'h80));
      send(rnd_data(), '1, 1'b0, 1'b0);
      send(rnd_data(), keep_n(1), 1'b1, 1'b0);
      chk("b129_ena", DW'(dcmac_tx_ena), DW'(8'h01));
      chk("b129_eop", DW'(dcmac_tx_eop), DW'(8'h01));
      chk("b129_mty0", DW'(dcmac_tx_mty[3:0]), DW'(15));
      chk("b129_vld", DW'(dcmac_tx_vld), DW'(4'b0001));
      send(rnd_data(), '1, 1'b0, 1'b0);
      send(rnd_data(), keep_n(40), 1'b1, 1'b1);
      chk("user_err", DW'(dcmac_tx_err), DW'(8'h04));
      chk("user_perr", DW'(proto_err), DW'(0));
      send(rnd_data(), '1, 1'b1, 1'b0);
      dcmac_tx_tready = 1'b0;
      send(rnd_data(), '1, 1'b1, 1'b0);
      chk("skid_tready_low", DW'(casper_tx_tready), DW'(0));
      dcmac_tx_tready = 1'b1;
      @(posedge clk);
      #1;
      chk("skid_tready_back", DW'(casper_tx_tready), DW'(1));
      drain();
      chk_stats();
      stall_en = 1'b1;
      for (int p = 0; p < 2; p++) begin
         for (int b = 0; b < 64; b++) send(rnd_data(), '1, b == 63, 1'b0);
         @(posedge clk);
         #1;
      end
      for (int p = 0; p < 30; p++) begin
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            last = b == nb - 1;
            send(rnd_data(), last ? keep_n($urandom_range(1, KW)) : '1, last, last ? 1'($urandom_range(0, 1)) : 1'b0);
         end
         repeat ($urandom_range(0, 1)) @(posedge clk);
         #1;
      end
      stall_en = 1'b0;
      @(posedge clk);
      #1;
      dcmac_tx_tready = 1'b1;
      dcmac_tx_af = 1'b0;
      drain();
      chk("legal_perr", DW'(proto_err), DW'(exp_perr));
      chk_stats();
      send(rnd_data(), keep_n(8), 1'b0, 1'b0);
      chk("short_err", DW'(dcmac_tx_err), DW'(8'h01));
      chk("short_perr", DW'(proto_err), DW'(1));
      send(rnd_data(), '1, 1'b1, 1'b0);
      send(rnd_data(), KW'(128'h00FF_00FF), 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("perr_sticky", DW'(proto_err), DW'(exp_perr));
      drain();
      chk_stats();
      for (int b = 0; b < 3; b++) send(rnd_data(), '1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_ena", DW'(dcmac_tx_ena), DW'(0));
      chk("mid_rst_tready", DW'(casper_tx_tready), DW'(0));
      chk("mid_rst_perr", DW'(proto_err), DW'(0));
      chk("mid_rst_pkt", DW'(pkt_cnt), DW'(0));
      q.delete();
      in_pkt = 1'b0;
      exp_perr = 1'b0;
      exp_pkts = 0;
      exp_errs = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send(rnd_data(), '1, 1'b0, 1'b0);
      chk("post_rst_sop", DW'(dcmac_tx_sop), DW'(8'h01));
      send(rnd_data(), keep_n(77), 1'b1, 1'b0);
      drain();
      chk_stats();
      chk("final_perr", DW'(proto_err), DW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
